// File: rtl/mips_pkg.sv
// Shared encodings for the MEM stage: access size codes, memory FSM states
// and the writeback select values that ride along to MEM/WB.
package mips_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mau_state_e;

endpackage

// File: rtl/load_extend.sv
// Load lane extraction: picks the addressed byte or half of a little-endian
// read word and sign- or zero-extends it to 32 bits. Word loads pass unmodified.
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (size)
      MEM_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      MEM_HALF: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: drives the data-memory req/ack handshake, forms byte
// enables and store lanes, extends load data and stalls the pipe while waiting.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic [4:0]  regdst,
  input  logic [31:0] pc_in,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [1:0]  memtoreg,
  input  logic        regwrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] ALUResult_out,
  output logic [31:0] mem_read_out,
  output logic [4:0]  regdst_out,
  output logic [31:0] pc_out,
  output logic [1:0]  memtoreg_out,
  output logic        regwrite_out,
  output logic        stall,
  output logic        misalign_exc,
  output logic        bus_err
);

  mau_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_op;
  logic             misaligned;
  logic             at_timeout;
  logic             access_done;
  logic [1:0]       lane;
  logic [31:0]      load_data;

  assign mem_op     = valid_in & (memread | memwrite);
  assign lane       = alu_result[1:0];
  assign at_timeout = (cnt_q == CNT_W'(TIMEOUT));

  assign ALUResult_out = alu_result;
  assign regdst_out    = regdst;
  assign pc_out        = pc_in;
  assign memtoreg_out  = memtoreg;
  assign dmem_addr     = {alu_result[31:2], 2'b00};

  always_comb begin
    case (mem_size)
      MEM_BYTE: misaligned = 1'b0;
      MEM_HALF: misaligned = lane[0];
      default:  misaligned = |lane;
    endcase
  end

  // Store lanes; loads always read the full word.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = write_data;
    if (memwrite) begin
      case (mem_size)
        MEM_BYTE: begin
          dmem_be    = 4'b0001 << lane;
          dmem_wdata = {4{write_data[7:0]}};
        end
        MEM_HALF: begin
          dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{write_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_extend u_load_extend (
    .rdata       (dmem_rdata),
    .lane        (lane),
    .size        (mem_size),
    .is_unsigned (mem_unsigned),
    .data        (load_data)
  );

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op && !misaligned && !dmem_ack) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (dmem_ack || at_timeout) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // While waiting the EX/MEM inputs are frozen by stall, so the request
  // fields stay stable without a capture register.
  always_comb begin
    dmem_req     = 1'b0;
    stall        = 1'b0;
    bus_err      = 1'b0;
    misalign_exc = 1'b0;
    access_done  = 1'b0;
    regwrite_out = 1'b0;
    mem_read_out = '0;

    if (!reset) begin
      misalign_exc = mem_op & misaligned;
      regwrite_out = regwrite & valid_in & ~mem_op;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!mem_op) begin
            regwrite_out = regwrite & valid_in;
          end else if (misaligned) begin
            misalign_exc = 1'b1;
          end else begin
            dmem_req = 1'b1;
            if (dmem_ack) access_done = 1'b1;
            else          stall       = 1'b1;
          end
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            dmem_req    = 1'b1;
            access_done = 1'b1;
          end else if (at_timeout) begin
            bus_err = 1'b1;
          end else begin
            dmem_req = 1'b1;
            stall    = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (access_done) begin
      regwrite_out = regwrite & valid_in;
      mem_read_out = (memread && !memwrite) ? load_data : '0;
    end
  end

  assign dmem_we = dmem_req & memwrite;

endmodule
